// File: rtl/spawn_pkg.sv
// Shared definitions for the spawn scheduler: FSM encoding, parameter defaults
// and the inter-spawn delay arithmetic.
package spawn_pkg;

    localparam int unsigned X_MAX_DEFAULT       = 160;
    localparam int unsigned DELAY_BASE_DEFAULT  = 1000;
    localparam int unsigned DELAY_SCALE_DEFAULT = 4;
    localparam int unsigned MAX_RETRY_DEFAULT   = 7;

    typedef enum logic [2:0] {
        ST_SEED,
        ST_IDLE,
        ST_DRAW_DELAY,
        ST_LOAD_DELAY,
        ST_WAIT,
        ST_DRAW_X,
        ST_CHECK_X,
        ST_PRESENT
    } state_t;

    function automatic logic [31:0] calc_delay(input logic [31:0] base,
                                               input logic [31:0] scale,
                                               input logic [7:0]  field);
        return base + ({24'd0, field} * scale);
    endfunction

endpackage

// File: rtl/spawn_delay_counter.sv
// Loadable 32-bit down-counter timing the gap between spawns.
module spawn_delay_counter (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_value,
    input  logic        i_tick,
    output logic        o_zero
);

    logic [31:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    // High while the count reads 1 (or 0): the current tick is the last one.
    assign o_zero = (r_count <= 32'd1);

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: waits a random delay, draws a random X below X_MAX with
// bounded retries, presents it and counts accepted spawns.
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int unsigned X_MAX       = X_MAX_DEFAULT,
    parameter int unsigned DELAY_BASE  = DELAY_BASE_DEFAULT,
    parameter int unsigned DELAY_SCALE = DELAY_SCALE_DEFAULT,
    parameter int unsigned MAX_RETRY   = MAX_RETRY_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_restartGame,
    input  logic [25:0] i_randomNumber,
    input  logic        i_spawnAck,
    output logic        o_generateNumber,
    output logic        o_resetNumberGenerator,
    output logic        o_spawnValid,
    output logic [7:0]  o_spawnX,
    output logic [15:0] o_spawnCount
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [8:0]  XMAX_9  = 9'(X_MAX);
    localparam logic [7:0]  XMAX_8  = 8'(X_MAX);

    state_t               r_state;
    state_t               w_next;
    logic [RETRY_W-1:0]   r_retry;
    logic [7:0]           r_spawnX;
    logic [15:0]          r_spawnCount;

    logic                 w_cnt_load;
    logic [31:0]          w_cnt_value;
    logic                 w_cnt_tick;
    logic                 w_cnt_zero;
    logic                 w_retry_clr;
    logic                 w_retry_inc;
    logic                 w_x_latch;
    logic [7:0]           w_x_val;
    logic                 w_count_inc;
    logic                 w_count_clr;
    logic                 w_x_ok;
    logic                 w_retry_max;
    logic [31:0]          w_delay;
    logic                 w_unused_rn;

    assign w_x_ok      = ({1'b0, i_randomNumber[7:0]} < XMAX_9);
    assign w_retry_max = (r_retry == RETRY_W'(MAX_RETRY));
    assign w_delay     = calc_delay(DELAY_BASE, DELAY_SCALE, i_randomNumber[25:18]);
    assign w_unused_rn = ^i_randomNumber[17:8];

    spawn_delay_counter u_delay (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_tick  (w_cnt_tick),
        .o_zero  (w_cnt_zero)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_SEED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next                 = r_state;
        w_cnt_load             = 1'b0;
        w_cnt_value            = '0;
        w_cnt_tick             = 1'b0;
        w_retry_clr            = 1'b0;
        w_retry_inc            = 1'b0;
        w_x_latch              = 1'b0;
        w_x_val                = i_randomNumber[7:0];
        w_count_inc            = 1'b0;
        w_count_clr            = 1'b0;
        o_generateNumber       = 1'b0;
        o_resetNumberGenerator = 1'b0;
        o_spawnValid           = 1'b0;

        case (r_state)
            ST_SEED: begin
                // State is already SEED while reset is held; keep the reseed quiet until release.
                o_resetNumberGenerator = !i_reset;
                w_next                 = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_enable) w_next = ST_DRAW_DELAY;
            end
            ST_DRAW_DELAY: begin
                o_generateNumber = 1'b1;
                if (i_enable) begin
                    w_next = ST_LOAD_DELAY;
                end else begin
                    w_cnt_load = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            ST_LOAD_DELAY: begin
                w_cnt_load = 1'b1;
                if (i_enable) begin
                    w_cnt_value = w_delay;
                    w_next      = ST_WAIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_enable) begin
                    w_cnt_load = 1'b1;
                    w_next     = ST_IDLE;
                end else begin
                    w_cnt_tick = 1'b1;
                    if (w_cnt_zero) w_next = ST_DRAW_X;
                end
            end
            ST_DRAW_X: begin
                o_generateNumber = 1'b1;
                w_next           = ST_CHECK_X;
            end
            ST_CHECK_X: begin
                if (w_x_ok) begin
                    w_x_latch = 1'b1;
                    w_next    = ST_PRESENT;
                end else if (!w_retry_max) begin
                    w_retry_inc = 1'b1;
                    w_next      = ST_DRAW_X;
                end else begin
                    w_x_latch = 1'b1;
                    w_x_val   = i_randomNumber[7:0] - XMAX_8;
                    w_next    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                o_spawnValid = 1'b1;
                if (i_spawnAck) begin
                    w_count_inc = 1'b1;
                    w_next      = i_enable ? ST_DRAW_DELAY : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_SEED;
            end
        endcase

        if (i_restartGame) begin
            w_next      = ST_SEED;
            w_cnt_load  = 1'b1;
            w_cnt_value = '0;
            w_cnt_tick  = 1'b0;
            w_retry_inc = 1'b0;
            w_x_latch   = 1'b0;
            w_count_inc = 1'b0;
            w_count_clr = 1'b1;
        end

        if (w_next == ST_DRAW_DELAY) w_retry_clr = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_retry      <= '0;
            r_spawnX     <= '0;
            r_spawnCount <= '0;
        end else begin
            if (w_retry_clr) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_x_latch) r_spawnX <= w_x_val;
            if (w_count_clr) begin
                r_spawnCount <= '0;
            end else if (w_count_inc) begin
                r_spawnCount <= r_spawnCount + 16'd1;
            end
        end
    end

    assign o_spawnX     = r_spawnX;
    assign o_spawnCount = r_spawnCount;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Randomized bench for spawn_scheduler; the bench plays the upstream generator
// and predicts each spawn from the drawn values with plain arithmetic.
module tb_spawn_scheduler;

    localparam int unsigned XM = 160;
    localparam int unsigned DB = 10;
    localparam int unsigned DS = 1;
    localparam int unsigned MR = 7;

    logic        clk = 1'b0;
    logic        i_reset, i_enable, i_restartGame, i_spawnAck;
    logic [25:0] i_randomNumber;
    logic        o_generateNumber, o_resetNumberGenerator, o_spawnValid;
    logic [7:0]  o_spawnX;
    logic [15:0] o_spawnCount;

    always #5 clk = ~clk;

    spawn_scheduler #(
        .X_MAX       (XM),
        .DELAY_BASE  (DB),
        .DELAY_SCALE (DS),
        .MAX_RETRY   (MR)
    ) dut (
        .i_clock                (clk),
        .i_reset                (i_reset),
        .i_enable               (i_enable),
        .i_restartGame          (i_restartGame),
        .i_randomNumber         (i_randomNumber),
        .i_spawnAck             (i_spawnAck),
        .o_generateNumber       (o_generateNumber),
        .o_resetNumberGenerator (o_resetNumberGenerator),
        .o_spawnValid           (o_spawnValid),
        .o_spawnX               (o_spawnX),
        .o_spawnCount           (o_spawnCount)
    );

    logic [25:0] vals [256];
    int          idx;
    logic        gen_s, rng_s, val_s;
    logic [7:0]  x_s;
    logic [15:0] cnt_s;
    logic [15:0] exp_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        gen_s = o_generateNumber;
        rng_s = o_resetNumberGenerator;
        val_s = o_spawnValid;
        x_s   = o_spawnX;
        cnt_s = o_spawnCount;
    endtask

    // Generator reacts at the edge to the request seen in the previous cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rng_s) idx = 0;
        else if (gen_s) idx = (idx + 1) % 256;
        i_randomNumber = vals[idx];
        sample();
    endtask

    function automatic void predict(input int base, output int d, output int draws,
                                    output logic [7:0] x);
        logic [25:0] v;
        bit          done;
        v     = vals[base];
        d     = int'(DB) + int'(v[25:18]) * int'(DS);
        draws = 0;
        x     = '0;
        done  = 1'b0;
        for (int k = 0; k <= int'(MR); k++) begin
            if (!done) begin
                v     = vals[(base + 1 + k) % 256];
                draws = k + 1;
                if (v[7:0] < XM) begin
                    x    = v[7:0];
                    done = 1'b1;
                end else if (k == int'(MR)) begin
                    x    = 8'(int'(v[7:0]) - int'(XM));
                    done = 1'b1;
                end
            end
        end
    endfunction

    // mode 0: normal, 1: drop enable during draws, 2: drop enable in PRESENT,
    // 3: restartGame together with spawnAck in PRESENT.
    task automatic run_spawn(input int mode, input int ack_wait,
                             output int w_meas, output int d_meas, output logic [7:0] x_meas);
        int         n, base, d, draws, draws_exp;
        logic [7:0] x_exp;
        w_meas   = -1;
        d_meas   = -1;
        x_meas   = '0;
        i_enable = 1'b1;
        n = 0;
        while (!gen_s && n < 50) begin
            cycle();
            n++;
        end
        if (!gen_s) begin
            chk_eq("draw_delay_timeout", 0, 1);
            return;
        end
        base = (idx + 1) % 256;
        predict(base, d, draws_exp, x_exp);
        n = 0;
        do begin
            i_spawnAck = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end while (!gen_s && n < 400);
        chk_eq("wait_len", n, d + 2);
        w_meas = n - 2;
        draws  = 1;
        if (mode == 1) i_enable = 1'b0;
        n = 0;
        do begin
            i_spawnAck = 1'($urandom_range(0, 1));
            cycle();
            n++;
            if (gen_s) draws++;
        end while (!val_s && n < 60);
        i_spawnAck = 1'b0;
        chk_eq("valid_up", val_s, 1);
        if (!val_s) return;
        d_meas = draws;
        x_meas = x_s;
        chk_eq("draws", draws, draws_exp);
        chk_eq("spawnX", x_s, x_exp);
        chk_eq("cnt_before_ack", cnt_s, exp_cnt);
        if (mode == 2) i_enable = 1'b0;
        for (int i = 0; i < ack_wait; i++) begin
            cycle();
            chk_eq("valid_hold", val_s, 1);
            chk_eq("x_hold", x_s, x_exp);
        end
        if (mode == 3) begin
            i_restartGame = 1'b1;
            i_spawnAck    = 1'b1;
            cycle();
            i_restartGame = 1'b0;
            i_spawnAck    = 1'b0;
            exp_cnt       = '0;
            chk_eq("restart_valid", val_s, 0);
            chk_eq("restart_cnt", cnt_s, 0);
            chk_eq("restart_rng", rng_s, 1);
            chk_eq("restart_gen", gen_s, 0);
            cycle();
            chk_eq("seed_one_cycle", rng_s, 0);
        end else begin
            i_spawnAck = 1'b1;
            cycle();
            i_spawnAck = 1'b0;
            exp_cnt    = exp_cnt + 16'd1;
            chk_eq("cnt_after_ack", cnt_s, exp_cnt);
            chk_eq("valid_after_ack", val_s, 0);
            chk_eq("next_after_ack", gen_s, i_enable);
        end
    endtask

    task automatic abort_wait();
        int         n, k, d, dr, pulses;
        logic [7:0] xe;
        i_enable = 1'b1;
        n = 0;
        while (!gen_s && n < 50) begin
            cycle();
            n++;
        end
        if (!gen_s) begin
            chk_eq("abort_dd_timeout", 0, 1);
            return;
        end
        predict((idx + 1) % 256, d, dr, xe);
        k = $urandom_range(2, d + 1);
        for (int i = 0; i < k; i++) cycle();
        chk_eq("abort_in_wait", gen_s, 0);
        i_enable = 1'b0;
        cycle();
        chk_eq("abort_idle", {gen_s, val_s}, 0);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (gen_s || val_s) pulses++;
        end
        chk_eq("abort_quiet", pulses, 0);
        chk_eq("abort_cnt", cnt_s, exp_cnt);
        i_enable = 1'b1;
        cycle();
        chk_eq("reenable_draw", gen_s, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         w, dr, mode;
        logic [7:0] x;

        for (int i = 0; i < 256; i++) vals[i] = 26'($urandom);
        vals[1][25:18] = 8'd5;
        vals[2][7:0]   = 8'h40;
        for (int i = 4; i <= 10; i++) vals[i][7:0] = 8'hC8;
        vals[11][7:0] = 8'h10;
        for (int i = 13; i <= 20; i++) vals[i][7:0] = 8'hC8;

        idx            = 0;
        gen_s          = 1'b0;
        rng_s          = 1'b0;
        val_s          = 1'b0;
        x_s            = '0;
        cnt_s          = '0;
        exp_cnt        = '0;
        i_reset        = 1'b1;
        i_enable       = 1'b0;
        i_restartGame  = 1'b0;
        i_spawnAck     = 1'b0;
        i_randomNumber = vals[0];

        repeat (3) cycle();
        chk_eq("rst_gen", gen_s, 0);
        chk_eq("rst_rng", rng_s, 0);
        chk_eq("rst_valid", val_s, 0);
        chk_eq("rst_x", x_s, 0);
        chk_eq("rst_cnt", cnt_s, 0);

        i_reset = 1'b0;
        #1;
        sample();
        chk_eq("release_rng", rng_s, 1);
        chk_eq("release_gen", gen_s, 0);
        repeat (5) begin
            cycle();
            chk_eq("idle_outputs", {rng_s, gen_s, val_s, x_s, cnt_s}, 0);
        end

        run_spawn(0, 2, w, dr, x);
        chk_eq("first_wait", w, 15);
        chk_eq("first_x", x, 64);
        chk_eq("first_cnt", cnt_s, 1);

        run_spawn(0, 0, w, dr, x);
        chk_eq("retry_draws", dr, 8);
        chk_eq("retry_x", x, 16);

        run_spawn(0, 1, w, dr, x);
        chk_eq("fallback_draws", dr, 8);
        chk_eq("fallback_x", x, 40);

        abort_wait();
        run_spawn(0, 1, w, dr, x);
        run_spawn(2, 3, w, dr, x);
        run_spawn(1, 0, w, dr, x);
        run_spawn(3, 2, w, dr, x);

        repeat (14) begin
            mode = $urandom_range(0, 3);
            run_spawn(mode, $urandom_range(0, 4), w, dr, x);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
